// File: rtl/bp_pkg.sv
// Shared encodings and BTB entry layout for the gshare branch predictor.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic KIND_COND = 1'b0;
    localparam logic KIND_JUMP = 1'b1;

    // Tag field is sized for the widest supported tag; narrower tags are zero-extended.
    localparam int TAG_MAX = 32;

    typedef struct packed {
        logic               valid;
        logic [TAG_MAX-1:0] tag;
        logic [31:0]        target;
        logic               kind;
    } btb_entry_t;

endpackage

// File: rtl/bp_sat_counter_update.sv
// Next-state function of a 2-bit saturating direction counter.
module bp_sat_counter_update
    import bp_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] nextCtr
);

    always_comb begin
        nextCtr = cur;
        if (taken && cur != ST) begin
            nextCtr = cur + 2'd1;
        end else if (!taken && cur != SNT) begin
            nextCtr = cur - 2'd1;
        end
    end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Fetch-stage predictor: tagged BTB plus gshare PHT, with a speculative
// global history that Execute repairs on mispredict.
module gshare_branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int GHR_BITS = 6,
    parameter int TAG_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         PCF,
    input  logic                StallF,
    output logic                PredTakenF,
    output logic [31:0]         PredPCTargetF,
    output logic [GHR_BITS-1:0] GhrF,
    input  logic                UpdateE,
    input  logic                KindE,
    input  logic [31:0]         PCE,
    input  logic [31:0]         PCTargetE,
    input  logic                TakenE,
    input  logic [GHR_BITS-1:0] GhrE,
    input  logic                MispredictE,
    output logic [31:0]         MispredCount
);

    localparam int IDX = $clog2(ENTRIES);

    btb_entry_t          btb [ENTRIES];
    logic [1:0]          pht [ENTRIES];
    logic [GHR_BITS-1:0] ghr;
    logic [31:0]         mispredCount;

    logic [IDX-1:0]      lookIdx, lookPhtIdx, trainIdx, trainPhtIdx;
    logic [TAG_BITS-1:0] lookTag, trainTag;
    btb_entry_t          lookEntry;
    logic                hit, effTaken, repairGhr, specShift;
    logic [1:0]          trainCtr, trainCtrNext;
    logic [GHR_BITS-1:0] repairedGhr, shiftedGhr;
    logic                unusedPcBits;

    // Address bits outside the index and tag slices play no part in prediction.
    assign unusedPcBits = ^{PCF, PCE};

    assign lookIdx    = PCF[IDX+1:2];
    assign lookTag    = PCF[IDX+2+TAG_BITS-1:IDX+2];
    assign lookPhtIdx = lookIdx ^ IDX'(ghr);
    assign lookEntry  = btb[lookIdx];
    assign hit        = lookEntry.valid && (lookEntry.tag == TAG_MAX'(lookTag));

    assign PredTakenF    = hit && (lookEntry.kind || pht[lookPhtIdx][1]);
    assign PredPCTargetF = PredTakenF ? lookEntry.target : 32'd0;
    assign GhrF          = ghr;

    assign trainIdx    = PCE[IDX+1:2];
    assign trainTag    = PCE[IDX+2+TAG_BITS-1:IDX+2];
    assign trainPhtIdx = trainIdx ^ IDX'(GhrE);
    assign effTaken    = (KindE == KIND_JUMP) || TakenE;
    assign trainCtr    = pht[trainPhtIdx];

    bp_sat_counter_update u_ctrUpdate (
        .cur     (trainCtr),
        .taken   (TakenE),
        .nextCtr (trainCtrNext)
    );

    generate
        if (GHR_BITS == 1) begin : gen_ghr1
            assign repairedGhr = effTaken;
            assign shiftedGhr  = PredTakenF;
        end else begin : gen_ghrN
            assign repairedGhr = {GhrE[GHR_BITS-2:0], effTaken};
            assign shiftedGhr  = {ghr[GHR_BITS-2:0], PredTakenF};
        end
    endgenerate

    assign repairGhr = UpdateE && MispredictE;
    assign specShift = !StallF && hit && (lookEntry.kind == KIND_COND);

    // Only valid bits are reset; tag/target/kind payload is don't-care while invalid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb[i].valid <= 1'b0;
            end
        end else if (UpdateE && effTaken) begin
            btb[trainIdx] <= '{valid: 1'b1, tag: TAG_MAX'(trainTag),
                               target: PCTargetE, kind: KindE};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht[i] <= WNT;
            end
        end else if (UpdateE && KindE == KIND_COND) begin
            pht[trainPhtIdx] <= trainCtrNext;
        end
    end

    // Repair outranks the speculative shift so the redirected fetch sees true history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr <= '0;
        end else if (repairGhr) begin
            ghr <= repairedGhr;
        end else if (specShift) begin
            ghr <= shiftedGhr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mispredCount <= 32'd0;
        end else if (repairGhr && mispredCount != 32'hFFFF_FFFF) begin
            mispredCount <= mispredCount + 32'd1;
        end
    end

    assign MispredCount = mispredCount;

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed scoreboard bench for gshare_branch_predictor (default build plus a
// 16-entry build sharing the stimulus for the tag-alias check).
module tb_gshare_branch_predictor;

    localparam int S_PRED  = 0;
    localparam int S_TGT   = 1;
    localparam int S_GHR   = 2;
    localparam int S_CNT   = 3;
    localparam int S_APRED = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF, PCE, PCTargetE;
    logic        StallF, UpdateE, KindE, TakenE, MispredictE;
    logic [5:0]  GhrE;

    logic        PredTakenF, aPredTakenF;
    logic [31:0] PredPCTargetF, aPredPCTargetF;
    logic [5:0]  GhrF;
    logic [3:0]  aGhrF;
    logic [31:0] MispredCount, aMispredCount;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    gshare_branch_predictor dut (
        .clk(clk), .reset(reset), .PCF(PCF), .StallF(StallF),
        .PredTakenF(PredTakenF), .PredPCTargetF(PredPCTargetF), .GhrF(GhrF),
        .UpdateE(UpdateE), .KindE(KindE), .PCE(PCE), .PCTargetE(PCTargetE),
        .TakenE(TakenE), .GhrE(GhrE), .MispredictE(MispredictE),
        .MispredCount(MispredCount)
    );

    gshare_branch_predictor #(.ENTRIES(16), .GHR_BITS(4), .TAG_BITS(8)) dutAlias (
        .clk(clk), .reset(reset), .PCF(PCF), .StallF(StallF),
        .PredTakenF(aPredTakenF), .PredPCTargetF(aPredPCTargetF), .GhrF(aGhrF),
        .UpdateE(UpdateE), .KindE(KindE), .PCE(PCE), .PCTargetE(PCTargetE),
        .TakenE(TakenE), .GhrE(GhrE[3:0]), .MispredictE(MispredictE),
        .MispredCount(aMispredCount)
    );

    function automatic logic [31:0] observe(int sel);
        case (sel)
            S_PRED:  return {31'd0, PredTakenF};
            S_TGT:   return PredPCTargetF;
            S_GHR:   return {26'd0, GhrF};
            S_CNT:   return MispredCount;
            S_APRED: return {31'd0, aPredTakenF};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic pushExp(string t, int sel, logic [31:0] v);
        sb.push_back('{t, sel, v});
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.sel);
            total++;
            assert (o === e.exp) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(string t, logic [31:0] pc, logic expTaken, logic [31:0] expTgt);
        PCF = pc;
        #1;
        pushExp({t, "_pred"}, S_PRED, {31'd0, expTaken});
        pushExp({t, "_tgt"}, S_TGT, expTgt);
        drain();
    endtask

    task automatic train(logic [31:0] pc, logic [31:0] tgt, logic kind, logic taken,
                         logic [5:0] ghrE, logic mis);
        UpdateE = 1'b1; PCE = pc; PCTargetE = tgt; KindE = kind;
        TakenE = taken; GhrE = ghrE; MispredictE = mis;
        tick();
        UpdateE = 1'b0; MispredictE = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; PCF = 32'h100; StallF = 1'b1; UpdateE = 1'b0; KindE = 1'b0;
        PCE = 32'd0; PCTargetE = 32'd0; TakenE = 1'b0; GhrE = 6'd0; MispredictE = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        pushExp("rst_ghr", S_GHR, 32'd0);
        pushExp("rst_cnt", S_CNT, 32'd0);
        drain();
        lookup("rst", 32'h100, 1'b0, 32'd0);

        // jump allocation and repair shifts in a 1
        train(32'h200, 32'h340, 1'b1, 1'b0, 6'd0, 1'b1);
        pushExp("jmp_ghr", S_GHR, 32'h01);
        pushExp("jmp_cnt", S_CNT, 32'd1);
        drain();
        lookup("jmp", 32'h200, 1'b1, 32'h340);
        StallF = 1'b0;
        tick();
        pushExp("jmp_noshift", S_GHR, 32'h01);
        drain();
        StallF = 1'b1;

        reset = 1'b0; tick(); reset = 1'b1; tick();
        lookup("br_cold", 32'h40, 1'b0, 32'd0);

        // same-cycle lookup of the entry being written sees old contents
        UpdateE = 1'b1; PCE = 32'h40; PCTargetE = 32'h80; KindE = 1'b0;
        TakenE = 1'b1; GhrE = 6'd0; MispredictE = 1'b0;
        lookup("nobypass", 32'h40, 1'b0, 32'd0);
        tick();
        UpdateE = 1'b0;
        lookup("br_t1", 32'h40, 1'b1, 32'h80);
        train(32'h40, 32'h80, 1'b0, 1'b1, 6'd0, 1'b0);
        lookup("br_t2", 32'h40, 1'b1, 32'h80);
        train(32'h40, 32'h80, 1'b0, 1'b1, 6'd0, 1'b0);
        lookup("br_t3", 32'h40, 1'b1, 32'h80);

        lookup("alias_main", 32'h440, 1'b0, 32'd0);
        pushExp("alias_miss", S_APRED, 32'd0);
        drain();
        PCF = 32'h40; #1;
        pushExp("alias_hit", S_APRED, 32'd1);
        drain();

        train(32'h40, 32'hBAD0, 1'b0, 1'b0, 6'd0, 1'b0);
        lookup("br_nt1", 32'h40, 1'b1, 32'h80);
        train(32'h40, 32'hBAD0, 1'b0, 1'b0, 6'd0, 1'b0);
        lookup("br_nt2", 32'h40, 1'b0, 32'd0);
        train(32'h40, 32'hBAD0, 1'b0, 1'b0, 6'd0, 1'b0);
        lookup("br_nt3", 32'h40, 1'b0, 32'd0);
        train(32'h40, 32'hBAD0, 1'b0, 1'b0, 6'd0, 1'b0);
        lookup("br_nt4", 32'h40, 1'b0, 32'd0);
        train(32'h40, 32'h80, 1'b0, 1'b1, 6'd0, 1'b0);
        lookup("br_resat1", 32'h40, 1'b0, 32'd0);
        train(32'h40, 32'h80, 1'b0, 1'b1, 6'd0, 1'b0);
        lookup("br_resat2", 32'h40, 1'b1, 32'h80);

        // repair beats a simultaneous speculative shift
        StallF = 1'b0;
        lookup("sim_pre", 32'h40, 1'b1, 32'h80);
        train(32'h300, 32'h500, 1'b0, 1'b1, 6'b101010, 1'b1);
        pushExp("sim_repair", S_GHR, 32'h15);
        drain();
        StallF = 1'b1;
        tick();
        pushExp("stall_hold", S_GHR, 32'h15);
        drain();
        StallF = 1'b0;
        lookup("spec_pre", 32'h40, 1'b0, 32'd0);
        tick();
        pushExp("spec_shift", S_GHR, 32'h2A);
        drain();
        PCF = 32'h100;
        tick();
        pushExp("miss_hold", S_GHR, 32'h2A);
        drain();
        StallF = 1'b1;

        pushExp("cnt_one", S_CNT, 32'd1);
        drain();
        MispredictE = 1'b1;
        tick();
        MispredictE = 1'b0;
        pushExp("cnt_noupd", S_CNT, 32'd1);
        drain();

        force dut.mispredCount = 32'hFFFF_FFFE;
        #1;
        release dut.mispredCount;
        pushExp("cnt_forced", S_CNT, 32'hFFFF_FFFE);
        drain();
        train(32'h300, 32'h500, 1'b1, 1'b0, 6'd0, 1'b1);
        pushExp("cnt_top", S_CNT, 32'hFFFF_FFFF);
        drain();
        train(32'h300, 32'h500, 1'b1, 1'b0, 6'd0, 1'b1);
        train(32'h300, 32'h500, 1'b1, 1'b0, 6'd0, 1'b1);
        pushExp("cnt_sat", S_CNT, 32'hFFFF_FFFF);
        drain();

        lookup("pre_rst", 32'h300, 1'b1, 32'h500);
        pushExp("pre_rst_ghr", S_GHR, 32'h01);
        drain();
        #2;
        reset = 1'b0;
        #1;
        pushExp("mid_rst_pred", S_PRED, 32'd0);
        pushExp("mid_rst_tgt", S_TGT, 32'd0);
        pushExp("mid_rst_ghr", S_GHR, 32'd0);
        pushExp("mid_rst_cnt", S_CNT, 32'd0);
        drain();
        tick();
        reset = 1'b1;
        tick();
        lookup("post_rst", 32'h300, 1'b0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gshare_branch_predictor.md
# gshare_branch_predictor

Parametrised fetch-stage branch predictor for the pipelined RISC-V core, generalising the fixed 10-bit-PC-indexed predictor. It combines a tagged branch target buffer (BTB) with a gshare pattern history table (PHT) indexed by PC XOR global history. It also keeps a speculative global history register (GHR) that is repaired on mispredict. Predictions are combinational in Fetch; training arrives from Execute and is visible to Fetch on the following cycle.

## Interface
Parameters:
- ENTRIES, 64: BTB and PHT depth; power of two, 4..1024; IDX = log2(ENTRIES).
- GHR_BITS, 6: global history length; 1..IDX.
- TAG_BITS, 8: BTB tag width, taken from PC[IDX+2+TAG_BITS-1 : IDX+2].

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- PCF  in  32  fetch PC.
- StallF  in  1  fetch stalled; no speculative GHR shift.
- PredTakenF  out  1  predict redirect.
- PredPCTargetF  out  32  predicted target; 0 when PredTakenF=0.
- GhrF  out  GHR_BITS  GHR snapshot, carried down the pipe with the instruction.
- UpdateE  in  1  Execute holds a branch or jump to train.
- KindE  in  1  0 = conditional branch, 1 = jal/jalr.
- PCE  in  32  PC of the Execute instruction.
- PCTargetE  in  32  resolved target.
- TakenE  in  1  resolved direction; ignored when KindE=1, which is treated as taken.
- GhrE  in  GHR_BITS  snapshot that travelled with the instruction.
- MispredictE  in  1  direction or target wrong; Fetch is being redirected this cycle.
- MispredCount  out  32  saturating count of cycles with UpdateE & MispredictE.

## Operation
- Lookup (combinational):
  - bi = PCF[IDX+1:2]; pi = bi XOR zero-extended GHR.
  - hit = valid[bi] & (tag[bi] == PCF tag slice).
  - PredTakenF = hit & (kind[bi] | pht[pi][1]).
  - PredPCTargetF = PredTakenF ? target[bi] : 0.
  - GhrF = current GHR.
- PHT: 2-bit saturating counters. Encodings SNT=00, WNT=01, WT=10, ST=11.
- Training, on UpdateE at the clock edge:
  - bi/tag come from PCE; pi = PCE[IDX+1:2] XOR GhrE.
  - BTB is written {valid=1, tag, target=PCTargetE, kind=KindE} only when the effective taken value is 1. Not-taken branches never allocate; an existing entry is left intact.
  - PHT[pi] trains only when KindE=0: increment if TakenE, else decrement, saturating at 11 and 00.
- GHR update, in priority order:
  1. UpdateE & MispredictE: GHR <= {GhrE[GHR_BITS-2:0], effective taken}. For GHR_BITS=1, GHR <= effective taken.
  2. Otherwise, if !StallF & hit & kind[bi]=0: GHR <= {GHR[GHR_BITS-2:0], PredTakenF}.
  3. Otherwise GHR holds.
- Jumps never shift the GHR speculatively. On repair they shift in 1.
- MispredCount increments by 1 per qualifying cycle and saturates at 32'hFFFF_FFFF.
- Reset (reset=0, asynchronous): all valid=0, all PHT=WNT, GHR=0, MispredCount=0. This gives PredTakenF=0, PredPCTargetF=0, GhrF=0. Target and tag arrays need no reset.

## Timing
- Lookup has zero latency: outputs depend on PCF and state only.
- A training write at edge N is visible to a lookup in cycle N+1.
- A same-cycle lookup of the entry being written returns the old contents; there is no bypass.
- Repair at edge N: GhrF reflects the repaired history from cycle N+1, matching the redirected fetch.
- Simultaneous mispredict repair and speculative shift: repair wins and the speculative shift is dropped.
- Reset asserted mid-operation clears state immediately. The first lookup after deassertion behaves as cold.
- PCF[1:0] and PCE[1:0] are ignored.

## Structure
- bp_pkg holds the counter encodings SNT/WNT/WT/ST, the btb_entry_t struct {valid, tag, target, kind}, and the KIND_COND/KIND_JUMP constants.
- One sub-module, bp_sat_counter_update: combinational 2-bit next-state function (cur, taken) -> next. It is instantiated once on the training path.
- The BTB and PHT are flop arrays; there is no SRAM macro at these depths.

## Test plan
- Reset then PCF=0x100 -> PredTakenF=0, PredPCTargetF=0, GhrF=0, MispredCount=0.
- Jump train: UpdateE, KindE=1, PCE=0x200, PCTargetE=0x340, MispredictE=1. Next cycle PCF=0x200 -> PredTakenF=1, PredPCTargetF=0x340, GHR=000001.
- Conditional branch at 0x40, target 0x80, GhrE=0:
  - Two taken updates move the counter WNT->WT->ST. Lookup then gives PredTakenF=1.
  - Three not-taken updates move it to SNT; a fourth update keeps SNT, and the lookup gives PredTakenF=0 with the BTB entry still valid.
- Alias check, ENTRIES=16: PCE=0x40 vs PCF=0x440, same index, different tag -> hit=0, PredTakenF=0 even when the PHT entry is ST.
- Simultaneous events: PCF hits a conditional entry with StallF=0 while UpdateE & MispredictE with GhrE=6'b101010, TakenE=1 -> next GHR=6'b010101. With StallF=1 and no mispredict -> GHR unchanged.
- Force MispredCount to 32'hFFFF_FFFE, then three mispredicts -> count reads FFFF_FFFF. Assert reset mid-stream -> every output is 0 within the same cycle.
